// File: rtl/me_search_ctrl_if.sv
// me_search_ctrl_if: command/result bundle between the motion-estimation
// sequencer and the SAD array / search client.
interface me_search_ctrl_if #(
  parameter int SAD_WIDTH = 16,
  parameter int NX        = 16,
  parameter int NY        = 16
) ();
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int RW = $clog2(NY + 16);

  logic                 start;
  logic [SAD_WIDTH-1:0] sad16x16;
  logic [1:0]           sel;
  logic [3:0]           curr_addr;
  logic [RW-1:0]        ref_row;
  logic [XW-1:0]        ref_col;
  logic                 busy;
  logic                 done;
  logic [SAD_WIDTH-1:0] best_sad;
  logic [XW-1:0]        mv_x;
  logic [YW-1:0]        mv_y;

  modport master (
    output start, sad16x16,
    input  sel, curr_addr, ref_row, ref_col,
    input  busy, done, best_sad, mv_x, mv_y
  );

  modport slave (
    input  start, sad16x16,
    output sel, curr_addr, ref_row, ref_col,
    output busy, done, best_sad, mv_x, mv_y
  );
endinterface

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search ME sequencer. Loads the current MB, scans
// the reference window column-major and keeps the minimum-SAD vector.
module me_search_ctrl #(
  parameter int PIX_WIDTH = 8,
  parameter int SAD_WIDTH = 16,
  parameter int NX        = 16,
  parameter int NY        = 16,
  parameter int SAD_LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  me_search_ctrl_if.slave bus
);
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int RW = $clog2(NY + 16);
  localparam int CW = $clog2(SAD_LAT + 16);

  typedef enum logic [2:0] {
    IDLE, LOAD_CURR, LOAD_REF, WAIT, COMPARE, SHIFT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [SAD_WIDTH-1:0] best_q, best_d;
  logic [XW-1:0]        mvx_q, mvx_d;
  logic [YW-1:0]        mvy_q, mvy_d;
  logic [1:0]           sel_q, sel_d;
  logic [3:0]           caddr_q, caddr_d;
  logic [RW-1:0]        rrow_q, rrow_d;
  logic [XW-1:0]        rcol_q, rcol_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next state, counters and best-candidate tracking.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    best_d  = best_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_CURR;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          best_d  = '1;
          mvx_d   = '0;
          mvy_d   = '0;
        end
      end
      LOAD_CURR: begin
        if (cnt_q == CW'(15)) begin
          state_d = LOAD_REF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD_REF: begin
        if (cnt_q == CW'(15)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CW'(SAD_LAT - 1)) begin
          state_d = COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMPARE: begin
        if (bus.sad16x16 < best_q) begin
          best_d = bus.sad16x16;
          mvx_d  = x_q;
          mvy_d  = y_q;
        end
        if (y_q != YW'(NY - 1)) begin
          state_d = SHIFT;
        end else if (x_q != XW'(NX - 1)) begin
          state_d = LOAD_REF;
          x_d     = x_q + XW'(1);
          y_d     = '0;
        end else begin
          state_d = DONE;
        end
      end
      SHIFT: begin
        state_d = WAIT;
        y_d     = y_q + YW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array command and flags decoded from the upcoming state.
  always_comb begin
    sel_d   = 2'd0;
    caddr_d = '0;
    rrow_d  = '0;
    rcol_d  = '0;
    case (state_d)
      LOAD_CURR: begin
        sel_d   = 2'd1;
        caddr_d = cnt_d[3:0];
      end
      LOAD_REF: begin
        sel_d  = 2'd2;
        rrow_d = RW'(y_d) + RW'(cnt_d[3:0]);
        rcol_d = x_d;
      end
      SHIFT: begin
        sel_d  = 2'd3;
        rrow_d = RW'(y_d) + RW'(16);
        rcol_d = x_d;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      best_q  <= '0;
      mvx_q   <= '0;
      mvy_q   <= '0;
      sel_q   <= '0;
      caddr_q <= '0;
      rrow_q  <= '0;
      rcol_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      best_q  <= best_d;
      mvx_q   <= mvx_d;
      mvy_q   <= mvy_d;
      sel_q   <= sel_d;
      caddr_q <= caddr_d;
      rrow_q  <= rrow_d;
      rcol_q  <= rcol_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.curr_addr = caddr_q;
  assign bus.ref_row   = rrow_q;
  assign bus.ref_col   = rcol_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.best_sad  = best_q;
  assign bus.mv_x      = mvx_q;
  assign bus.mv_y      = mvy_q;
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl: three configurations (2x2/L2, 1x1/L1, 2x3/L2)
// checked cycle by cycle against an expected command trace.
module tb_me_search_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_o;

  me_search_ctrl_if #(.SAD_WIDTH(16), .NX(2), .NY(2)) ifa ();
  me_search_ctrl_if #(.SAD_WIDTH(16), .NX(1), .NY(1)) ifb ();
  me_search_ctrl_if #(.SAD_WIDTH(16), .NX(2), .NY(3)) ifc ();

  me_search_ctrl #(
    .PIX_WIDTH(8), .SAD_WIDTH(16), .NX(2), .NY(2), .SAD_LAT(2)
  ) ua (.clk(clk), .rst(rst_a), .bus(ifa));
  me_search_ctrl #(
    .PIX_WIDTH(8), .SAD_WIDTH(16), .NX(1), .NY(1), .SAD_LAT(1)
  ) ub (.clk(clk), .rst(rst_o), .bus(ifb));
  me_search_ctrl #(
    .PIX_WIDTH(8), .SAD_WIDTH(16), .NX(2), .NY(3), .SAD_LAT(2)
  ) uc (.clk(clk), .rst(rst_o), .bus(ifc));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sel; int ca; int rr; int rc;
    int done; int cand; int wt;
  } ent_t;

  ent_t tr[$];
  int   sads[$];
  int   exp_best, exp_mx, exp_my;

  logic [31:0] o_sel, o_ca, o_rr, o_rc, o_busy, o_done;
  logic [31:0] o_best, o_mx, o_my;

  task automatic chk(input string tag, input logic [31:0] ob,
                     input int ex);
    total++;
    assert (ob === 32'(ex)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, ob, ex);
    end
  endtask

  task automatic sample(input int d);
    case (d)
      0: begin
        o_sel = 32'(ifa.sel);  o_ca = 32'(ifa.curr_addr);
        o_rr = 32'(ifa.ref_row); o_rc = 32'(ifa.ref_col);
        o_busy = 32'(ifa.busy); o_done = 32'(ifa.done);
        o_best = 32'(ifa.best_sad);
        o_mx = 32'(ifa.mv_x); o_my = 32'(ifa.mv_y);
      end
      1: begin
        o_sel = 32'(ifb.sel);  o_ca = 32'(ifb.curr_addr);
        o_rr = 32'(ifb.ref_row); o_rc = 32'(ifb.ref_col);
        o_busy = 32'(ifb.busy); o_done = 32'(ifb.done);
        o_best = 32'(ifb.best_sad);
        o_mx = 32'(ifb.mv_x); o_my = 32'(ifb.mv_y);
      end
      default: begin
        o_sel = 32'(ifc.sel);  o_ca = 32'(ifc.curr_addr);
        o_rr = 32'(ifc.ref_row); o_rc = 32'(ifc.ref_col);
        o_busy = 32'(ifc.busy); o_done = 32'(ifc.done);
        o_best = 32'(ifc.best_sad);
        o_mx = 32'(ifc.mv_x); o_my = 32'(ifc.mv_y);
      end
    endcase
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: ifa.start = v;
      1: ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  task automatic set_sad(input int d, input int v);
    case (d)
      0: ifa.sad16x16 = 16'(v);
      1: ifb.sad16x16 = 16'(v);
      default: ifc.sad16x16 = 16'(v);
    endcase
  endtask

  function automatic ent_t mk(int s, int c, int rr, int rc,
                              int dn, int cd, int w);
    ent_t e;
    e.sel = s; e.ca = c; e.rr = rr; e.rc = rc;
    e.done = dn; e.cand = cd; e.wt = w;
    return e;
  endfunction

  // Expected per-cycle view of one search, one entry per cycle
  // after the accepting edge; the last entry is the done cycle.
  task automatic build(input int nx, input int ny, input int lat);
    int w;
    w = 0;
    tr.delete();
    for (int r = 0; r < 16; r++) tr.push_back(mk(1, r, 0, 0, 0, -1, 0));
    for (int x = 0; x < nx; x++) begin
      for (int r = 0; r < 16; r++)
        tr.push_back(mk(2, 0, r, x, 0, -1, 0));
      for (int y = 0; y < ny; y++) begin
        w++;
        for (int l = 0; l < lat; l++)
          tr.push_back(mk(0, 0, 0, 0, 0, -1, w));
        tr.push_back(mk(0, 0, 0, 0, 0, x * ny + y, 0));
        if (y < ny - 1) tr.push_back(mk(3, 0, y + 16, x, 0, -1, 0));
      end
    end
    tr.push_back(mk(0, 0, 0, 0, 1, -1, 0));
  endtask

  // Minimum over candidates in scan order; first minimum wins.
  task automatic model(input int ny);
    exp_best = 65535; exp_mx = 0; exp_my = 0;
    foreach (sads[k]) begin
      if (sads[k] < exp_best) begin
        exp_best = sads[k];
        exp_mx = k / ny;
        exp_my = k % ny;
      end
    end
  endtask

  task automatic fill_rand(input int n);
    sads.delete();
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) sads.push_back(65535);
      else sads.push_back(int'($urandom_range(0, 12)));
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge idle.
  task automatic run(input int d, input int nx, input int ny,
                     input int lat, input bit hold, input string nm);
    int fd;
    string t;
    build(nx, ny, lat);
    model(ny);
    fd = -1;
    set_start(d, 1'b1);
    for (int j = 0; j < tr.size(); j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0 && !hold) set_start(d, 1'b0);
      sample(d);
      t = $sformatf("%s j%0d", nm, j);
      chk({t, " sel"}, o_sel, tr[j].sel);
      chk({t, " curr_addr"}, o_ca, tr[j].ca);
      chk({t, " ref_row"}, o_rr, tr[j].rr);
      chk({t, " ref_col"}, o_rc, tr[j].rc);
      chk({t, " busy"}, o_busy, 1);
      chk({t, " done"}, o_done, tr[j].done);
      if (fd < 0 && o_done === 32'd1) fd = j;
      if (tr[j].cand >= 0) set_sad(d, sads[tr[j].cand]);
      else set_sad(d, int'($urandom_range(0, 3)));
      if (tr[j].done != 0) begin
        chk({t, " best_sad"}, o_best, exp_best);
        chk({t, " mv_x"}, o_mx, exp_mx);
        chk({t, " mv_y"}, o_my, exp_my);
      end
    end
    chk({nm, " done latency"}, 32'(fd),
        16 + nx * (16 + ny * (lat + 1) + (ny - 1)));
    @(posedge clk);
    @(negedge clk);
    sample(d);
    chk({nm, " idle busy"}, o_busy, 0);
    chk({nm, " idle done"}, o_done, 0);
    chk({nm, " idle sel"}, o_sel, 0);
    chk({nm, " hold best_sad"}, o_best, exp_best);
    chk({nm, " hold mv_x"}, o_mx, exp_mx);
    chk({nm, " hold mv_y"}, o_my, exp_my);
  endtask

  task automatic chk_zero(input int d, input string nm);
    sample(d);
    chk({nm, " sel"}, o_sel, 0);
    chk({nm, " curr_addr"}, o_ca, 0);
    chk({nm, " ref_row"}, o_rr, 0);
    chk({nm, " ref_col"}, o_rc, 0);
    chk({nm, " busy"}, o_busy, 0);
    chk({nm, " done"}, o_done, 0);
    chk({nm, " best_sad"}, o_best, 0);
    chk({nm, " mv_x"}, o_mx, 0);
    chk({nm, " mv_y"}, o_my, 0);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_o = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    ifa.sad16x16 = '0; ifb.sad16x16 = '0; ifc.sad16x16 = '0;
    repeat (3) @(negedge clk);
    chk_zero(0, "rst A");
    chk_zero(1, "rst B");
    chk_zero(2, "rst C");
    rst_a = 1'b1;
    rst_o = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0, "idle A");

    // 2x2: ties keep the first candidate
    sads = '{40, 30, 30, 50};
    run(0, 2, 2, 2, 1'b0, "A tie");

    // start held high: one search, next accepted straight after done
    fill_rand(4);
    run(0, 2, 2, 2, 1'b1, "A held1");
    fill_rand(4);
    run(0, 2, 2, 2, 1'b0, "A held2");

    // reset in the second WAIT aborts with everything cleared
    build(2, 2, 2);
    ifa.start = 1'b1;
    for (int j = 0; j < tr.size(); j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0) ifa.start = 1'b0;
      if (tr[j].wt == 2) break;
    end
    rst_a = 1'b0;
    #1;
    chk_zero(0, "abort");
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample(0);
      chk($sformatf("post-abort busy %0d", k), o_busy, 0);
      chk($sformatf("post-abort done %0d", k), o_done, 0);
    end
    fill_rand(4);
    run(0, 2, 2, 2, 1'b0, "A after abort");

    // all-ones SADs never beat the initial best
    sads = '{65535, 65535, 65535, 65535};
    run(0, 2, 2, 2, 1'b0, "A all-ones");

    // single candidate
    sads = '{7};
    run(1, 1, 1, 1, 1'b0, "B single");
    fill_rand(1);
    run(1, 1, 1, 1, 1'b0, "B rand");

    // 2x3: SHIFT rows 16/17, column 1 reloads from row 0
    for (int n = 0; n < 3; n++) begin
      fill_rand(6);
      run(2, 2, 3, 2, 1'b0, $sformatf("C rand%0d", n));
    end
    for (int n = 0; n < 3; n++) begin
      fill_rand(4);
      run(0, 2, 2, 2, 1'b0, $sformatf("A rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
